decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   Registered MIPS ID stage between fetch and execute: decodes one instruction per accepted beat into
//   control/operand fields, holds them in an output register with valid/ready handshake,
//   inserts one bubble on load-use hazards, supports flush, counts illegal encodings.
// PARAMETERS
//   ALU_CTR_W  4  width of alu_ctr (>=4)
//   EXT_OPS    0  1: also decode ORI(001101), SLT(funct 101010), J(000010); 0: these are illegal
//   ERR_CNT_W  8  width of saturating illegal-instruction counter
// PORTS
//   clk          in   1          rising-edge clock
//   rst_n        in   1          asynchronous reset, active low
//   flush        in   1          discard held/incoming instruction (branch redirect)
//   in_valid     in   1          instr valid from fetch
//   in_ready     out  1          stage accepts instr this cycle
//   instr        in   32         instruction word
//   out_valid    out  1          decoded bundle valid
//   out_ready    in   1          execute consumes bundle
//   alu_ctr      out  ALU_CTR_W  ADD=0000 SUB=0001 AND=1001 OR=1010 NOR=1100 SLT=0111
//   reg_dst, reg_write, alu_src, sign_ext, mem_read, mem_write, branch, jump, illegal  out 1 each
//   rs, rt, rd, shamt  out 5     instruction fields
//   imm_ext      out  32         imm16 sign- or zero-extended per sign_ext
//   jump_index   out  26         instr[25:0]
//   err_count    out  ERR_CNT_W  illegal instructions accepted, saturating
// BEHAVIOUR
//   - Reset: all outputs 0 except in_ready=1; state RUN; load flag cleared; err_count=0.
//   - Latency 1: instr accepted on cycle N (in_valid & in_ready) appears on outputs from cycle N+1.
//   - Output reg holds while out_valid & !out_ready; in_ready = (!out_valid | out_ready) & !hazard & !flush.
//   - Decode: R-type (op 000000) funct 100000/100001 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR,
//     [EXT] 101010 SLT: reg_dst=1 reg_write=1 alu_src=0.
//     ADDI 001000: ADD, alu_src=1 sign_ext=1 reg_write=1.  ANDI 001100: AND, alu_src=1 sign_ext=0 reg_write=1.
//     [EXT] ORI 001101: OR, zero-ext.  LW 100011: ADD alu_src=1 sign_ext=1 mem_read=1 reg_write=1.
//     SW 101011: ADD alu_src=1 sign_ext=1 mem_write=1.  BEQ 000100: SUB sign_ext=1 branch=1.  [EXT] J 000010: jump=1.
//     Anything else: illegal=1, all other controls 0 (no writes); fields still reported.
//   - Load-use: load flag+load_rt set when an LW with rt!=0 is accepted; cleared on next accept or bubble.
//     hazard = flag & in_valid & (rs==load_rt | (uses_rt & rt==load_rt)); uses_rt for R-type, BEQ, SW.
//   - FSM RUN/BUBBLE: RUN & hazard & (!out_valid|out_ready): out_valid<=0 next cycle, instr not accepted,
//     flag cleared, go BUBBLE. BUBBLE: in_ready per normal rule (hazard now 0), back to RUN next cycle.
//   - flush: next cycle out_valid=0, flag cleared, state RUN, no accept that cycle; overrides hazard and accept.
//   - err_count += 1 per accepted illegal instr, holds at all-ones.
//   - Reset mid-operation: immediate return to reset values; in-flight bundle discarded.
// TESTING
//   1 Reset, in_valid=1 instr=0x00221820, out_ready=1 -> next cycle out_valid=1 alu_ctr=0000 reg_dst=1 rs=1 rt=2 rd=3.
//   2 0x2001FFFF then 0x3001FFFF -> imm_ext=0xFFFFFFFF alu_src=1; then imm_ext=0x0000FFFF alu_ctr=1001.
//   3 0x8C220004 then 0x00411820 back-to-back -> LW out, then one cycle out_valid=0 in_ready=0, ADD out after.
//   4 0x8C220004 then 0x00221820 with out_ready=0 2 cycles -> LW held stable, in_ready=0, then bubble, ADD.
//   5 0x10220003 accepted, flush=1 next cycle -> out_valid=0 following cycle, load flag cleared, no hazard.
//   6 EXT_OPS=0: 0xFC000000 x300 -> illegal=1 reg_write=0 mem_write=0, err_count saturates at 255.

Source files
------------

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
//   Bundles every signal exchanged between the MIPS decode stage and its
//   neighbours: the fetch-side valid/ready/instr handshake, the branch-redirect
//   flush, the execute-side valid/ready handshake with the decoded bundle, and
//   the illegal-instruction counter.
//
//   Modports
//     slave  : the decode stage itself (consumes instr, produces the bundle)
//     master : the surrounding pipeline (fetch + execute + redirect logic)
//
//   Signals
//     flush                      redirect: drop held/incoming instruction
//     in_valid / in_ready        fetch handshake
//     instr[31:0]                instruction word
//     out_valid / out_ready      execute handshake
//     alu_ctr[ALU_CTR_W-1:0]     ALU operation
//     reg_dst .. illegal         one-bit control flags
//     rs, rt, rd, shamt          raw instruction fields
//     imm_ext[31:0]              extended immediate
//     jump_index[25:0]           instr[25:0]
//     err_count[ERR_CNT_W-1:0]   saturating illegal-instruction count
// -----------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int ALU_CTR_W = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr;
    logic                 out_valid;
    logic                 out_ready;
    logic [ALU_CTR_W-1:0] alu_ctr;
    logic                 reg_dst;
    logic                 reg_write;
    logic                 alu_src;
    logic                 sign_ext;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch;
    logic                 jump;
    logic                 illegal;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [4:0]           shamt;
    logic [31:0]          imm_ext;
    logic [25:0]          jump_index;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  flush, in_valid, instr, out_ready,
        output in_ready, out_valid, alu_ctr, reg_dst, reg_write, alu_src,
               sign_ext, mem_read, mem_write, branch, jump, illegal,
               rs, rt, rd, shamt, imm_ext, jump_index, err_count
    );

    modport master (
        output flush, in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_ctr, reg_dst, reg_write, alu_src,
               sign_ext, mem_read, mem_write, branch, jump, illegal,
               rs, rt, rd, shamt, imm_ext, jump_index, err_count
    );
endinterface

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Registered MIPS instruction-decode stage sitting between fetch and execute.
//   One instruction is decoded per accepted beat; the decoded bundle is held in
//   an output register under a valid/ready handshake (latency 1). A load-use
//   hazard inserts exactly one bubble, flush drops the held/incoming beat, and
//   illegal encodings are counted in a saturating counter.
//
//   Parameters
//     ALU_CTR_W  width of alu_ctr (>= 4)
//     EXT_OPS    1: ORI, SLT and J are decoded; 0: they are reported illegal
//     ERR_CNT_W  width of err_count
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    decode_stage_if.slave (handshakes, decoded bundle, err_count)
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int ALU_CTR_W = 4,
    parameter int EXT_OPS   = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    decode_stage_if.slave   bus
);

    // ---------------------------------------------------------------------
    // Encodings
    // ---------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_OR   = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    localparam bit EXT = (EXT_OPS != 0);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // Instruction fields of the incoming word
    // ---------------------------------------------------------------------
    logic [5:0] in_op;
    logic [5:0] in_funct;
    logic [4:0] in_rs;
    logic [4:0] in_rt;

    assign in_op    = bus.instr[31:26];
    assign in_funct = bus.instr[5:0];
    assign in_rs    = bus.instr[25:21];
    assign in_rt    = bus.instr[20:16];

    // ---------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ---------------------------------------------------------------------
    logic [3:0] dec_alu;
    logic       dec_reg_dst;
    logic       dec_reg_write;
    logic       dec_alu_src;
    logic       dec_sign_ext;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_illegal;

    always_comb begin
        dec_alu       = ALU_ADD;
        dec_reg_dst   = 1'b0;
        dec_reg_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_sign_ext  = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;

        case (in_op)
            OP_RTYPE: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                case (in_funct)
                    FN_ADD, FN_ADDU: dec_alu = ALU_ADD;
                    FN_SUB:          dec_alu = ALU_SUB;
                    FN_AND:          dec_alu = ALU_AND;
                    FN_OR:           dec_alu = ALU_OR;
                    FN_NOR:          dec_alu = ALU_NOR;
                    FN_SLT: begin
                        if (EXT) begin
                            dec_alu = ALU_SLT;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    default:         dec_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_alu       = ALU_ADD;
                dec_alu_src   = 1'b1;
                dec_sign_ext  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec_alu       = ALU_AND;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_ORI: begin
                if (EXT) begin
                    dec_alu       = ALU_OR;
                    dec_alu_src   = 1'b1;
                    dec_reg_write = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_LW: begin
                dec_alu       = ALU_ADD;
                dec_alu_src   = 1'b1;
                dec_sign_ext  = 1'b1;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_SW: begin
                dec_alu       = ALU_ADD;
                dec_alu_src   = 1'b1;
                dec_sign_ext  = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_alu      = ALU_SUB;
                dec_sign_ext = 1'b1;
                dec_branch   = 1'b1;
            end
            OP_J: begin
                if (EXT) begin
                    dec_jump = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase

        // An illegal word must never write anything downstream, so every
        // control is forced low regardless of what the R-type arm set.
        if (dec_illegal) begin
            dec_alu       = ALU_ADD;
            dec_reg_dst   = 1'b0;
            dec_reg_write = 1'b0;
            dec_alu_src   = 1'b0;
            dec_sign_ext  = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_branch    = 1'b0;
            dec_jump      = 1'b0;
        end
    end

    // Immediate extension: upper half replicates bit 15 only when signed.
    logic [15:0] dec_imm_hi;
    logic [31:0] dec_imm;

    for (genvar gi = 0; gi < 16; gi++) begin : g_imm_hi
        assign dec_imm_hi[gi] = dec_sign_ext & bus.instr[15];
    end

    assign dec_imm = {dec_imm_hi, bus.instr[15:0]};

    // Formats that read rt as a source (R-type, BEQ, SW). Other formats
    // write rt, so a match there is not a dependency.
    logic uses_rt;
    assign uses_rt = (in_op == OP_RTYPE) | (in_op == OP_BEQ) | (in_op == OP_SW);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t               state_reg;
    logic                 out_valid_reg;
    logic                 load_flag_reg;
    logic [4:0]           load_rt_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;

    logic [ALU_CTR_W-1:0] alu_ctr_reg;
    logic                 reg_dst_reg;
    logic                 reg_write_reg;
    logic                 alu_src_reg;
    logic                 sign_ext_reg;
    logic                 mem_read_reg;
    logic                 mem_write_reg;
    logic                 branch_reg;
    logic                 jump_reg;
    logic                 illegal_reg;
    logic [4:0]           rs_reg;
    logic [4:0]           rt_reg;
    logic [4:0]           rd_reg;
    logic [4:0]           shamt_reg;
    logic [31:0]          imm_ext_reg;
    logic [25:0]          jump_index_reg;

    // ---------------------------------------------------------------------
    // Handshake and hazard
    // ---------------------------------------------------------------------
    logic hazard;
    logic out_free;
    logic in_ready;
    logic accept;
    logic take_bubble;

    // The load flag only survives until the very next accept or bubble, so
    // it only ever guards the instruction directly behind the load.
    assign hazard = load_flag_reg & bus.in_valid &
                    ((in_rs == load_rt_reg) | (uses_rt & (in_rt == load_rt_reg)));

    assign out_free    = ~out_valid_reg | bus.out_ready;
    assign in_ready    = out_free & ~hazard & ~bus.flush;
    assign accept      = bus.in_valid & in_ready;
    // The bubble only starts once the load has actually left the register;
    // while it is stalled downstream the hazard just holds in_ready low.
    assign take_bubble = (state_reg == ST_RUN) & hazard & out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RUN;
            out_valid_reg  <= 1'b0;
            load_flag_reg  <= 1'b0;
            load_rt_reg    <= 5'd0;
            err_count_reg  <= '0;
            alu_ctr_reg    <= '0;
            reg_dst_reg    <= 1'b0;
            reg_write_reg  <= 1'b0;
            alu_src_reg    <= 1'b0;
            sign_ext_reg   <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            branch_reg     <= 1'b0;
            jump_reg       <= 1'b0;
            illegal_reg    <= 1'b0;
            rs_reg         <= 5'd0;
            rt_reg         <= 5'd0;
            rd_reg         <= 5'd0;
            shamt_reg      <= 5'd0;
            imm_ext_reg    <= 32'd0;
            jump_index_reg <= 26'd0;
        end else if (bus.flush) begin
            // Redirect wins over everything: drop the beat, forget the load.
            state_reg     <= ST_RUN;
            out_valid_reg <= 1'b0;
            load_flag_reg <= 1'b0;
        end else if (take_bubble) begin
            state_reg     <= ST_BUBBLE;
            out_valid_reg <= 1'b0;
            load_flag_reg <= 1'b0;
        end else begin
            // BUBBLE lasts exactly one cycle; RUN stays RUN.
            state_reg <= ST_RUN;
            if (accept) begin
                out_valid_reg  <= 1'b1;
                alu_ctr_reg    <= ALU_CTR_W'(dec_alu);
                reg_dst_reg    <= dec_reg_dst;
                reg_write_reg  <= dec_reg_write;
                alu_src_reg    <= dec_alu_src;
                sign_ext_reg   <= dec_sign_ext;
                mem_read_reg   <= dec_mem_read;
                mem_write_reg  <= dec_mem_write;
                branch_reg     <= dec_branch;
                jump_reg       <= dec_jump;
                illegal_reg    <= dec_illegal;
                rs_reg         <= in_rs;
                rt_reg         <= in_rt;
                rd_reg         <= bus.instr[15:11];
                shamt_reg      <= bus.instr[10:6];
                imm_ext_reg    <= dec_imm;
                jump_index_reg <= bus.instr[25:0];
                // A load into $0 produces nothing, so it cannot be a hazard.
                load_flag_reg  <= dec_mem_read & (in_rt != 5'd0);
                load_rt_reg    <= in_rt;
                if (dec_illegal && (err_count_reg != '1)) begin
                    err_count_reg <= err_count_reg + ERR_CNT_W'(1);
                end
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_reg;
    assign bus.alu_ctr    = alu_ctr_reg;
    assign bus.reg_dst    = reg_dst_reg;
    assign bus.reg_write  = reg_write_reg;
    assign bus.alu_src    = alu_src_reg;
    assign bus.sign_ext   = sign_ext_reg;
    assign bus.mem_read   = mem_read_reg;
    assign bus.mem_write  = mem_write_reg;
    assign bus.branch     = branch_reg;
    assign bus.jump       = jump_reg;
    assign bus.illegal    = illegal_reg;
    assign bus.rs         = rs_reg;
    assign bus.rt         = rt_reg;
    assign bus.rd         = rd_reg;
    assign bus.shamt      = shamt_reg;
    assign bus.imm_ext    = imm_ext_reg;
    assign bus.jump_index = jump_index_reg;
    assign bus.err_count  = err_count_reg;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Self-checking bench for decode_stage (EXT_OPS=0). Directed sequences cover
//   reset, latency, load-use bubble (with and without back-pressure), flush,
//   counter saturation and asynchronous reset; a vector table with random
//   back-pressure covers the decode map. Every accepted instruction pushes its
//   expected bundle to a scoreboard that is checked when execute consumes it.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int ALU_CTR_W = 4;
    localparam int ERR_CNT_W = 8;

    // {reg_dst, reg_write, alu_src, sign_ext, mem_read, mem_write, branch, jump, illegal}
    localparam logic [8:0] CTL_R    = 9'b110000000;
    localparam logic [8:0] CTL_ADDI = 9'b011100000;
    localparam logic [8:0] CTL_ANDI = 9'b011000000;
    localparam logic [8:0] CTL_LW   = 9'b011110000;
    localparam logic [8:0] CTL_SW   = 9'b001101000;
    localparam logic [8:0] CTL_BEQ  = 9'b000100100;
    localparam logic [8:0] CTL_ILL  = 9'b000000001;

    typedef logic [90:0] bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu;
        logic [8:0]  ctl;
        logic [31:0] imm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.ALU_CTR_W(ALU_CTR_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

    decode_stage #(
        .ALU_CTR_W (ALU_CTR_W),
        .EXT_OPS   (0),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int      n_vec = 0;
    int      n_err = 0;
    int      n_xact = 0;
    bundle_t sb[$];
    bundle_t cur_exp = '0;
    bundle_t act_bundle;

    assign act_bundle = {bus.alu_ctr, bus.reg_dst, bus.reg_write, bus.alu_src,
                         bus.sign_ext, bus.mem_read, bus.mem_write, bus.branch,
                         bus.jump, bus.illegal, bus.rs, bus.rt, bus.rd, bus.shamt,
                         bus.imm_ext, bus.jump_index};

    function automatic bundle_t mk_exp(input logic [31:0] i, input logic [3:0] alu,
                                       input logic [8:0] ctl, input logic [31:0] imm);
        return {alu, ctl, i[25:21], i[20:16], i[15:11], i[10:6], imm, i[25:0]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] i, input logic [3:0] alu,
                         input logic [8:0] ctl, input logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.instr    = i;
        cur_exp      = mk_exp(i, alu, ctl, imm);
    endtask

    // Scoreboard: push on fetch handshake, pop and compare on execute handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(cur_exp);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got bundle %0h, required no output", act_bundle);
                end else begin
                    bundle_t e;
                    e = sb.pop_front();
                    n_xact++;
                    $display("xact %0d: bundle %h", n_xact, act_bundle);
                    chk("sb_bundle", act_bundle, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[18];
    bit   acc;

    initial begin
        tbl[0]  = '{32'h00221820, 4'b0000, CTL_R,    32'h00001820};
        tbl[1]  = '{32'h2001FFFF, 4'b0000, CTL_ADDI, 32'hFFFFFFFF};
        tbl[2]  = '{32'h3001FFFF, 4'b1001, CTL_ANDI, 32'h0000FFFF};
        tbl[3]  = '{32'h00221822, 4'b0001, CTL_R,    32'h00001822};
        tbl[4]  = '{32'h00221824, 4'b1001, CTL_R,    32'h00001824};
        tbl[5]  = '{32'h00221825, 4'b1010, CTL_R,    32'h00001825};
        tbl[6]  = '{32'h00221827, 4'b1100, CTL_R,    32'h00001827};
        tbl[7]  = '{32'h00221821, 4'b0000, CTL_R,    32'h00001821};
        tbl[8]  = '{32'h0022182A, 4'b0000, CTL_ILL,  32'h0000182A};
        tbl[9]  = '{32'h3421ABCD, 4'b0000, CTL_ILL,  32'h0000ABCD};
        tbl[10] = '{32'h08000010, 4'b0000, CTL_ILL,  32'h00000010};
        tbl[11] = '{32'hAC450008, 4'b0000, CTL_SW,   32'h00000008};
        tbl[12] = '{32'h8C620010, 4'b0000, CTL_LW,   32'h00000010};
        tbl[13] = '{32'h1022FFFE, 4'b0001, CTL_BEQ,  32'hFFFFFFFE};
        tbl[14] = '{32'h20038000, 4'b0000, CTL_ADDI, 32'hFFFF8000};
        tbl[15] = '{32'hFC000000, 4'b0000, CTL_ILL,  32'h00000000};
        tbl[16] = '{32'h00000000, 4'b0000, CTL_ILL,  32'h00000000};
        tbl[17] = '{32'h30008001, 4'b1001, CTL_ANDI, 32'h00008001};

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'd0;
        bus.out_ready = 1'b1;

        // ---- reset state ----
        mid();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_err_count", bus.err_count, 8'd0);
        chk("rst_bundle", act_bundle, '0);
        tick();
        rst_n = 1'b1;

        // ---- ADD, latency 1 ----
        drive(32'h00221820, 4'b0000, CTL_R, 32'h00001820);
        mid();
        chk("add_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        mid();
        chk("add_out_valid", bus.out_valid, 1'b1);
        chk("add_alu_ctr", bus.alu_ctr, 4'b0000);
        chk("add_reg_dst", bus.reg_dst, 1'b1);
        chk("add_rs", bus.rs, 5'd1);
        chk("add_rt", bus.rt, 5'd2);
        chk("add_rd", bus.rd, 5'd3);

        // ---- ADDI then ANDI: sign vs zero extension ----
        tick();
        drive(32'h2001FFFF, 4'b0000, CTL_ADDI, 32'hFFFFFFFF);
        tick();
        drive(32'h3001FFFF, 4'b1001, CTL_ANDI, 32'h0000FFFF);
        mid();
        chk("addi_imm", bus.imm_ext, 32'hFFFFFFFF);
        chk("addi_alu_src", bus.alu_src, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        mid();
        chk("andi_imm", bus.imm_ext, 32'h0000FFFF);
        chk("andi_alu_ctr", bus.alu_ctr, 4'b1001);

        // ---- load-use back-to-back: one bubble ----
        tick();
        drive(32'h8C220004, 4'b0000, CTL_LW, 32'h00000004);
        mid();
        chk("lu_lw_in_ready", bus.in_ready, 1'b1);
        tick();
        drive(32'h00411820, 4'b0000, CTL_R, 32'h00001820);
        mid();
        chk("lu_lw_out_valid", bus.out_valid, 1'b1);
        chk("lu_hazard_in_ready", bus.in_ready, 1'b0);
        tick();
        mid();
        chk("lu_bubble_out_valid", bus.out_valid, 1'b0);
        chk("lu_bubble_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        mid();
        chk("lu_add_out_valid", bus.out_valid, 1'b1);
        chk("lu_add_rs", bus.rs, 5'd2);

        // ---- load-use under back-pressure ----
        tick();
        bus.out_ready = 1'b0;
        drive(32'h8C220004, 4'b0000, CTL_LW, 32'h00000004);
        mid();
        chk("bp_lw_in_ready", bus.in_ready, 1'b1);
        tick();
        drive(32'h00221820, 4'b0000, CTL_R, 32'h00001820);
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("bp_hold_out_valid", bus.out_valid, 1'b1);
            chk("bp_hold_mem_read", bus.mem_read, 1'b1);
            chk("bp_hold_imm", bus.imm_ext, 32'h00000004);
            chk("bp_hold_in_ready", bus.in_ready, 1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        mid();
        chk("bp_release_in_ready", bus.in_ready, 1'b0);
        tick();
        mid();
        chk("bp_bubble_out_valid", bus.out_valid, 1'b0);
        chk("bp_bubble_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        mid();
        chk("bp_add_out_valid", bus.out_valid, 1'b1);
        chk("bp_add_rd", bus.rd, 5'd3);

        // ---- flush after BEQ, LW: load flag must be forgotten ----
        tick();
        drive(32'h10220003, 4'b0001, CTL_BEQ, 32'h00000003);
        tick();
        drive(32'h8C220004, 4'b0000, CTL_LW, 32'h00000004);
        mid();
        chk("fl_beq_branch", bus.branch, 1'b1);
        chk("fl_lw_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.flush = 1'b1;
        drive(32'h00411820, 4'b0000, CTL_R, 32'h00001820);
        mid();
        chk("fl_flush_in_ready", bus.in_ready, 1'b0);
        tick();
        bus.flush = 1'b0;
        mid();
        chk("fl_after_out_valid", bus.out_valid, 1'b0);
        chk("fl_no_hazard_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        mid();
        chk("fl_add_out_valid", bus.out_valid, 1'b1);
        chk("fl_add_rs", bus.rs, 5'd2);

        // ---- decode table with random back-pressure ----
        tick();
        foreach (tbl[i]) begin
            drive(tbl[i].instr, tbl[i].alu, tbl[i].ctl, tbl[i].imm);
            acc = 1'b0;
            for (int c = 0; c < 30 && !acc; c++) begin
                mid();
                acc = bus.in_ready;
                tick();
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            if (!acc) begin
                n_vec++;
                n_err++;
                $display("FAIL tbl_accept_timeout vec %0d: in_ready stayed 0, required 1", i);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        mid();
        chk("tbl_sb_empty", sb.size(), 0);
        chk("tbl_err_count", bus.err_count, 8'd5);

        // ---- 300 illegal words: counter saturates ----
        tick();
        drive(32'hFC000000, 4'b0000, CTL_ILL, 32'h00000000);
        for (int j = 0; j < 300; j++) begin
            mid();
            if (j == 100) chk("sat_err_count_mid", bus.err_count, 8'd105);
            tick();
        end
        bus.in_valid = 1'b0;
        mid();
        chk("sat_illegal", bus.illegal, 1'b1);
        chk("sat_reg_write", bus.reg_write, 1'b0);
        chk("sat_mem_write", bus.mem_write, 1'b0);
        chk("sat_err_count", bus.err_count, 8'd255);
        tick();
        mid();
        chk("sat_sb_empty", sb.size(), 0);

        // ---- asynchronous reset with a held bundle ----
        tick();
        bus.out_ready = 1'b0;
        drive(32'h00221820, 4'b0000, CTL_R, 32'h00001820);
        tick();
        bus.in_valid = 1'b0;
        mid();
        chk("ar_held_out_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", bus.out_valid, 1'b0);
        chk("ar_in_ready", bus.in_ready, 1'b1);
        chk("ar_err_count", bus.err_count, 8'd0);
        chk("ar_bundle", act_bundle, '0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        mid();
        chk("ar_post_out_valid", bus.out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
